// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//
// Purpose:
//   Shares the single port of the 4K x 16 data memory between the instruction
//   fetch requester (IF, read-only) and the data requester (D, read/write).
//   Every access is sequenced as grant -> issue -> read-latency wait ->
//   response. Addresses whose bits above MEM_AW are non-zero are rejected
//   with an error response and never reach the memory.
//
// Configuration macro:
//   ARB_ROUND_ROBIN_EN - when defined, simultaneous requests are granted to
//                        the port that did not win the previous grant.
//                        When undefined, D always wins over IF.
//
// Ports:
//   clk_i        system clock, all state changes on the rising edge
//   rst_n_i      asynchronous active-low reset
//   if_req_i     fetch request, held with if_addr_i until if_ack_o
//   if_addr_i    fetch address
//   if_ack_o     one-cycle fetch completion pulse
//   if_rdata_o   fetch read data, valid with if_ack_o, held otherwise
//   if_err_o     fetch address overflow, valid with if_ack_o
//   d_req_i      data request, held with d_rw_i/d_addr_i/d_wdata_i until d_ack_o
//   d_rw_i       0 = read, 1 = write
//   d_addr_i     data address
//   d_wdata_i    data write value
//   d_ack_o      one-cycle data completion pulse
//   d_rdata_o    data read result, valid with d_ack_o on reads, held otherwise
//   d_err_o      data address overflow, valid with d_ack_o
//   mem_en_o     memory strobe, one cycle per access
//   mem_rw_o     memory direction, 0 = read, 1 = write
//   mem_addr_o   memory address (low MEM_AW bits of the granted address)
//   mem_wdata_o  memory write data
//   mem_rdata_i  memory read data, valid READ_LAT cycles after mem_en_o
// ---------------------------------------------------------------------------
module mem_arbiter #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int MEM_AW   = 12,
  parameter int READ_LAT = 1
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_ack_o,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_err_o,
  input  logic              d_req_i,
  input  logic              d_rw_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic              d_ack_o,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              d_err_o,
  output logic              mem_en_o,
  output logic              mem_rw_o,
  output logic [MEM_AW-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  localparam int CNT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(READ_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t state_q, state_d;

  logic             selD_q, selD_d;
  logic             rw_q, rw_d;
  logic [CNT_W-1:0] waitCnt_q, waitCnt_d;

  logic              memEn_q, memEn_d;
  logic              memRw_q, memRw_d;
  logic [MEM_AW-1:0] memAddr_q, memAddr_d;
  logic [DATA_W-1:0] memWdata_q, memWdata_d;

  logic              ifAck_q, ifAck_d;
  logic              ifErr_q, ifErr_d;
  logic [DATA_W-1:0] ifRdata_q, ifRdata_d;
  logic              dAck_q, dAck_d;
  logic              dErr_q, dErr_d;
  logic [DATA_W-1:0] dRdata_q, dRdata_d;

`ifdef ARB_ROUND_ROBIN_EN
  logic lastGrantD_q, lastGrantD_d;
`endif

  logic              pickD;
  logic              reqRw;
  logic [ADDR_W-1:0] reqAddr;
  logic [DATA_W-1:0] reqWdata;
  logic              reqOk;
  logic              respNow;
  logic              respErr;
  logic              respLoad;

  // Next-state and next-output logic. All outputs are registered, so the
  // value each output register takes is decided here from the state being
  // entered: mem_* is loaded on the edge into ISSUE (and cleared otherwise),
  // the ack/err pulse is loaded on the edge into RESP. The winner is picked
  // straight from the request inputs in IDLE so the memory strobe can appear
  // in the very next cycle. Read data is taken from mem_rdata_i in the last
  // WAIT cycle and loaded directly into the winner's rdata register; rdata
  // registers otherwise hold their previous value.
  always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
    pickD        = d_req_i & (~if_req_i | ~lastGrantD_q);
    lastGrantD_d = lastGrantD_q;
`else
    pickD        = d_req_i;
`endif
    reqRw    = pickD & d_rw_i;
    reqAddr  = pickD ? d_addr_i : if_addr_i;
    reqWdata = (pickD && d_rw_i) ? d_wdata_i : '0;
    reqOk    = (reqAddr[ADDR_W-1:MEM_AW] == '0);

    state_d    = state_q;
    selD_d     = selD_q;
    rw_d       = rw_q;
    waitCnt_d  = waitCnt_q;
    memEn_d    = 1'b0;
    memRw_d    = 1'b0;
    memAddr_d  = '0;
    memWdata_d = '0;
    ifAck_d    = 1'b0;
    ifErr_d    = 1'b0;
    ifRdata_d  = ifRdata_q;
    dAck_d     = 1'b0;
    dErr_d     = 1'b0;
    dRdata_d   = dRdata_q;
    respNow    = 1'b0;
    respErr    = 1'b0;
    respLoad   = 1'b0;

    case (state_q)
      S_IDLE: begin
        waitCnt_d = '0;
        if (if_req_i || d_req_i) begin
          selD_d = pickD;
          rw_d   = reqRw;
`ifdef ARB_ROUND_ROBIN_EN
          lastGrantD_d = pickD;
`endif
          if (reqOk) begin
            state_d    = S_ISSUE;
            memEn_d    = 1'b1;
            memRw_d    = reqRw;
            memAddr_d  = reqAddr[MEM_AW-1:0];
            memWdata_d = reqWdata;
          end else begin
            state_d = S_RESP;
            respNow = 1'b1;
            respErr = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        if (rw_q) begin
          state_d = S_RESP;
          respNow = 1'b1;
        end else begin
          state_d   = S_WAIT;
          waitCnt_d = '0;
        end
      end
      S_WAIT: begin
        if (waitCnt_q == LAST_CNT) begin
          state_d   = S_RESP;
          waitCnt_d = '0;
          respNow   = 1'b1;
          respLoad  = 1'b1;
        end else begin
          waitCnt_d = waitCnt_q + CNT_W'(1);
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (respNow) begin
      if (selD_d) begin
        dAck_d = 1'b1;
        dErr_d = respErr;
        if (respLoad) begin
          dRdata_d = mem_rdata_i;
        end
      end else begin
        ifAck_d = 1'b1;
        ifErr_d = respErr;
        if (respLoad) begin
          ifRdata_d = mem_rdata_i;
        end
      end
    end
  end

  // State and output registers. Reset clears everything at once, which also
  // aborts any access in flight: the FSM lands in IDLE, so no ack can follow.
  // After reset the previous grant is taken to be IF.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= S_IDLE;
      selD_q     <= 1'b0;
      rw_q       <= 1'b0;
      waitCnt_q  <= '0;
      memEn_q    <= 1'b0;
      memRw_q    <= 1'b0;
      memAddr_q  <= '0;
      memWdata_q <= '0;
      ifAck_q    <= 1'b0;
      ifErr_q    <= 1'b0;
      ifRdata_q  <= '0;
      dAck_q     <= 1'b0;
      dErr_q     <= 1'b0;
      dRdata_q   <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      lastGrantD_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      selD_q     <= selD_d;
      rw_q       <= rw_d;
      waitCnt_q  <= waitCnt_d;
      memEn_q    <= memEn_d;
      memRw_q    <= memRw_d;
      memAddr_q  <= memAddr_d;
      memWdata_q <= memWdata_d;
      ifAck_q    <= ifAck_d;
      ifErr_q    <= ifErr_d;
      ifRdata_q  <= ifRdata_d;
      dAck_q     <= dAck_d;
      dErr_q     <= dErr_d;
      dRdata_q   <= dRdata_d;
`ifdef ARB_ROUND_ROBIN_EN
      lastGrantD_q <= lastGrantD_d;
`endif
    end
  end

  assign mem_en_o    = memEn_q;
  assign mem_rw_o    = memRw_q;
  assign mem_addr_o  = memAddr_q;
  assign mem_wdata_o = memWdata_q;
  assign if_ack_o    = ifAck_q;
  assign if_err_o    = ifErr_q;
  assign if_rdata_o  = ifRdata_q;
  assign d_ack_o     = dAck_q;
  assign d_err_o     = dErr_q;
  assign d_rdata_o   = dRdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
//
// Purpose:
//   Self-checking bench for mem_arbiter. A memory responder answers the
//   arbiter's memory port. A transaction-level reference model predicts, for
//   every clock cycle, the arbiter outputs from the request inputs, and one
//   compare process checks them. Directed scenarios pin exact latencies and
//   data values; a randomized phase then drives both ports concurrently.
//   Honours ARB_ROUND_ROBIN_EN if it is defined for the build.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int READ_LAT = 1;

  logic        clk;
  logic        rstN;
  logic        ifReq;
  logic [15:0] ifAddr;
  logic        ifAck;
  logic [15:0] ifRdata;
  logic        ifErr;
  logic        dReq;
  logic        dRw;
  logic [15:0] dAddr;
  logic [15:0] dWdata;
  logic        dAck;
  logic [15:0] dRdata;
  logic        dErr;
  logic        memEn;
  logic        memRw;
  logic [11:0] memAddr;
  logic [15:0] memWdata;
  logic [15:0] memRdata;

  int testsRun    = 0;
  int testsFailed = 0;
  int edgeCnt     = 0;

  mem_arbiter #(
    .ADDR_W  (16),
    .DATA_W  (16),
    .MEM_AW  (12),
    .READ_LAT(READ_LAT)
  ) dut (
    .clk_i      (clk),
    .rst_n_i    (rstN),
    .if_req_i   (ifReq),
    .if_addr_i  (ifAddr),
    .if_ack_o   (ifAck),
    .if_rdata_o (ifRdata),
    .if_err_o   (ifErr),
    .d_req_i    (dReq),
    .d_rw_i     (dRw),
    .d_addr_i   (dAddr),
    .d_wdata_i  (dWdata),
    .d_ack_o    (dAck),
    .d_rdata_o  (dRdata),
    .d_err_o    (dErr),
    .mem_en_o   (memEn),
    .mem_rw_o   (memRw),
    .mem_addr_o (memAddr),
    .mem_wdata_o(memWdata),
    .mem_rdata_i(memRdata)
  );

  // Free-running clock, first rising edge at 5 ns.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Preloaded memory contents; location 0x010 holds 0xBEEF.
  function automatic logic [15:0] initVal(input logic [11:0] a);
    if (a == 12'h010) return 16'hBEEF;
    return {a, 4'h5} ^ 16'h5A5A;
  endfunction

  function automatic logic [15:0] randAddr();
    logic [15:0] a;
    a = 16'($urandom_range(0, 31));
    if ($urandom_range(0, 7) == 0) a[15:12] = 4'($urandom_range(1, 15));
    return a;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Memory responder: writes land on the strobe edge; read data appears
  // READ_LAT cycles after the strobe and is random noise at other times so a
  // mistimed capture shows up.
  logic [15:0] memArr [4096];
  bit          memWritten [4096];
  logic [15:0] rdPipe [READ_LAT];

  always @(posedge clk) begin
    if (memEn && memRw) begin
      memArr[memAddr]     <= memWdata;
      memWritten[memAddr] <= 1'b1;
    end
    if (memEn && !memRw) rdPipe[0] <= memWritten[memAddr] ? memArr[memAddr] : initVal(memAddr);
    else rdPipe[0] <= 16'($urandom);
    for (int i = 1; i < READ_LAT; i++) rdPipe[i] <= rdPipe[i-1];
  end

  assign memRdata = rdPipe[READ_LAT-1];

  // Reference model state: one outstanding transaction described by the edge
  // its strobe appears after, the edge its ack appears after, and its fields.
  int          mNextSample;
  int          mMemEdge;
  int          mAckEdge;
  bit          mPortD;
  bit          mRw;
  bit          mOvf;
  bit          mLastD;
  logic [11:0] mAddr;
  logic [15:0] mWdata;
  logic [15:0] mRdata;
  logic [15:0] expIfRdata;
  logic [15:0] expDRdata;
  logic [15:0] shadow [4096];
  bit          shadowWritten [4096];

  // Model plus compare, once per cycle, 1 ns after the rising edge while the
  // request inputs still hold the values the arbiter just sampled.
  initial begin : compareProc
    logic [15:0] fullAddr;
    bit eMemEn;
    bit eAck;
    mNextSample = 0;
    mMemEdge    = -1;
    mAckEdge    = -1;
    mLastD      = 1'b0;
    mPortD      = 1'b0;
    mRw         = 1'b0;
    mOvf        = 1'b0;
    mAddr       = '0;
    mWdata      = '0;
    mRdata      = '0;
    expIfRdata  = '0;
    expDRdata   = '0;
    forever begin
      @(posedge clk);
      #1;
      edgeCnt++;
      if (!rstN) begin
        mNextSample = 0;
        mMemEdge    = -1;
        mAckEdge    = -1;
        mLastD      = 1'b0;
        expIfRdata  = '0;
        expDRdata   = '0;
      end else if (edgeCnt >= mNextSample && (ifReq || dReq)) begin
`ifdef ARB_ROUND_ROBIN_EN
        mPortD = dReq && (!ifReq || !mLastD);
`else
        mPortD = dReq;
`endif
        mLastD   = mPortD;
        fullAddr = mPortD ? dAddr : ifAddr;
        mRw      = mPortD && dRw;
        mWdata   = mRw ? dWdata : 16'h0;
        mOvf     = (fullAddr >= 16'h1000);
        mAddr    = fullAddr[11:0];
        if (mOvf) begin
          mMemEdge = -1;
          mAckEdge = edgeCnt;
        end else begin
          mMemEdge = edgeCnt;
          if (mRw) begin
            mAckEdge             = edgeCnt + 1;
            shadow[mAddr]        = mWdata;
            shadowWritten[mAddr] = 1'b1;
          end else begin
            mAckEdge = edgeCnt + 1 + READ_LAT;
            mRdata   = shadowWritten[mAddr] ? shadow[mAddr] : initVal(mAddr);
          end
        end
        mNextSample = mAckEdge + 2;
      end
      eMemEn = rstN && (mMemEdge == edgeCnt);
      eAck   = rstN && (mAckEdge == edgeCnt);
      if (eAck && !mOvf && !mRw) begin
        if (mPortD) expDRdata = mRdata;
        else expIfRdata = mRdata;
      end
      checkOutput("memEn",    memEn,    eMemEn);
      checkOutput("memRw",    memRw,    eMemEn && mRw);
      checkOutput("memAddr",  memAddr,  eMemEn ? mAddr : 12'h0);
      checkOutput("memWdata", memWdata, eMemEn ? mWdata : 16'h0);
      checkOutput("ifAck",    ifAck,    eAck && !mPortD);
      checkOutput("ifErr",    ifErr,    eAck && !mPortD && mOvf);
      checkOutput("ifRdata",  ifRdata,  expIfRdata);
      checkOutput("dAck",     dAck,     eAck && mPortD);
      checkOutput("dErr",     dErr,     eAck && mPortD && mOvf);
      checkOutput("dRdata",   dRdata,   expDRdata);
    end
  end

  // Observations from the last directed access.
  int          obsTs;
  int          obsMem;
  logic [11:0] obsMemAddr;
  logic        obsMemRw;
  int          obsAck;
  logic [15:0] obsRdata;
  logic        obsErr;

  // Issue one access from an idle arbiter and record when things happened.
  task automatic applyStimulus(input bit portD, input bit rw, input logic [15:0] addr, input logic [15:0] wdata);
    if (portD) begin
      dReq = 1'b1; dRw = rw; dAddr = addr; dWdata = wdata;
    end else begin
      ifReq = 1'b1; ifAddr = addr;
    end
    obsTs  = edgeCnt + 1;
    obsMem = -1;
    obsAck = -1;
    obsMemAddr = '0; obsMemRw = 1'b0; obsRdata = '0; obsErr = 1'b0;
    for (int k = 0; k < 40 && obsAck < 0; k++) begin
      @(negedge clk);
      if (memEn && obsMem < 0) begin
        obsMem = edgeCnt; obsMemAddr = memAddr; obsMemRw = memRw;
      end
      if (portD ? dAck : ifAck) begin
        obsAck = edgeCnt;
        obsRdata = portD ? dRdata : ifRdata;
        obsErr   = portD ? dErr : ifErr;
      end
    end
    if (portD) begin
      dReq = 1'b0; dRw = 1'b0; dAddr = '0; dWdata = '0;
    end else begin
      ifReq = 1'b0; ifAddr = '0;
    end
    checkOutput("ackSeen", obsAck >= 0, 1'b1);
    repeat (2) @(negedge clk);
  endtask

  task automatic pulseReset();
    @(negedge clk);
    rstN = 1'b0;
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);
  endtask

  bit grantOrder[$];

  // One requester that keeps presenting reads back-to-back, four in total.
  task automatic portLoop(input bit portD);
    bit got;
    for (int k = 0; k < 4; k++) begin
      if (portD) begin
        dReq = 1'b1; dRw = 1'b0; dAddr = 16'h0100 + 16'(k);
      end else begin
        ifReq = 1'b1; ifAddr = 16'h0200 + 16'(k);
      end
      got = 1'b0;
      for (int w = 0; w < 100 && !got; w++) begin
        @(negedge clk);
        if (portD ? dAck : ifAck) got = 1'b1;
      end
      if (got) grantOrder.push_back(portD);
    end
    if (portD) dReq = 1'b0;
    else ifReq = 1'b0;
  endtask

  task automatic runRandom(input int cycles);
    bit ifBusy;
    bit dBusy;
    bit newReq;
    ifBusy = 1'b0;
    dBusy  = 1'b0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (!ifBusy || ifAck) begin
        newReq = ifBusy ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 2) == 0);
        ifBusy = newReq;
        ifReq  = newReq;
        if (newReq) ifAddr = randAddr();
      end
      if (!dBusy || dAck) begin
        newReq = dBusy ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 2) == 0);
        dBusy = newReq;
        dReq  = newReq;
        if (newReq) begin
          dRw    = 1'($urandom_range(0, 1));
          dAddr  = randAddr();
          dWdata = 16'($urandom);
        end
      end
    end
    ifReq = 1'b0;
    dReq  = 1'b0;
  endtask

  // Directed scenarios followed by randomized traffic, then the summary.
  initial begin : stimulusProc
    int memSeen;
    int ackSeen;
    bit expD;
    rstN = 1'b1;
    ifReq = 1'b0; ifAddr = '0;
    dReq = 1'b0; dRw = 1'b0; dAddr = '0; dWdata = '0;
    #1;
    rstN = 1'b0;

    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checkOutput("rstRdata", {ifRdata, dRdata}, 64'h0);
      checkOutput("rstCtrl", {memWdata, memAddr, ifAck, ifErr, dAck, dErr, memEn, memRw}, 64'h0);
      ifReq = 1'($urandom); ifAddr = 16'($urandom);
      dReq = 1'($urandom); dRw = 1'($urandom); dAddr = 16'($urandom); dWdata = 16'($urandom);
    end
    ifReq = 1'b0; dReq = 1'b0;
    rstN = 1'b1;
    memSeen = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (memEn) memSeen++;
    end
    checkOutput("idleMemEn", memSeen, 0);

    $display("[TB] IF read of 0x0010");
    applyStimulus(1'b0, 1'b0, 16'h0010, 16'h0);
    checkOutput("t2MemEdge", obsMem, obsTs);
    checkOutput("t2MemAddr", obsMemAddr, 12'h010);
    checkOutput("t2MemRw", obsMemRw, 1'b0);
    checkOutput("t2AckEdge", obsAck, obsTs + 1 + READ_LAT);
    checkOutput("t2Rdata", obsRdata, 16'hBEEF);
    checkOutput("t2Err", obsErr, 1'b0);

    $display("[TB] D write then read of 0x0FFF");
    applyStimulus(1'b1, 1'b1, 16'h0FFF, 16'h1234);
    checkOutput("t3MemEdge", obsMem, obsTs);
    checkOutput("t3MemRw", obsMemRw, 1'b1);
    checkOutput("t3MemAddr", obsMemAddr, 12'hFFF);
    checkOutput("t3AckEdge", obsAck, obsTs + 1);
    applyStimulus(1'b1, 1'b0, 16'h0FFF, 16'h0);
    checkOutput("t3ReadAck", obsAck, obsTs + 1 + READ_LAT);
    checkOutput("t3Rdata", obsRdata, 16'h1234);

    $display("[TB] overflow addresses");
    applyStimulus(1'b1, 1'b0, 16'h1000, 16'h0);
    checkOutput("t5AckEdge1000", obsAck, obsTs);
    checkOutput("t5Err1000", obsErr, 1'b1);
    checkOutput("t5NoMem1000", obsMem, -1);
    applyStimulus(1'b1, 1'b0, 16'hF000, 16'h0);
    checkOutput("t5AckEdgeF000", obsAck, obsTs);
    checkOutput("t5ErrF000", obsErr, 1'b1);
    checkOutput("t5NoMemF000", obsMem, -1);
    applyStimulus(1'b0, 1'b0, 16'h2004, 16'h0);
    checkOutput("t5IfErr", obsErr, 1'b1);

    $display("[TB] reset during read wait");
    ifReq = 1'b1; ifAddr = 16'h0020;
    @(negedge clk);
    @(negedge clk);
    rstN = 1'b0;
    ifReq = 1'b0;
    #1;
    checkOutput("t6RstRdata", {ifRdata, dRdata}, 64'h0);
    checkOutput("t6RstCtrl", {memWdata, memAddr, ifAck, ifErr, dAck, dErr, memEn, memRw}, 64'h0);
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    ackSeen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (ifAck || dAck) ackSeen++;
    end
    checkOutput("t6NoAck", ackSeen, 0);
    applyStimulus(1'b0, 1'b0, 16'h0020, 16'h0);
    checkOutput("t6NextAck", obsAck, obsTs + 1 + READ_LAT);
    checkOutput("t6NextRdata", obsRdata, initVal(12'h020));

    $display("[TB] contention, both ports back-to-back");
    pulseReset();
    grantOrder.delete();
    fork
      portLoop(1'b0);
      portLoop(1'b1);
    join
    checkOutput("t4Grants", grantOrder.size(), 8);
    for (int k = 0; k < 8; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
      expD = (k % 2 == 0);
`else
      expD = (k < 4);
`endif
      checkOutput($sformatf("t4Grant%0d", k), (k < grantOrder.size()) ? 2'(grantOrder[k]) : 2'd2, 2'(expD));
    end
    repeat (3) @(negedge clk);

    $display("[TB] randomized traffic");
    runRandom(2000);
    repeat (10) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  // Hard stop in case something never returns.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
